// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: drives the PC generator's stall/update interface from
// EX-stage branch/jump resolution, trap requests, and hazard/memory stalls.
// Arbitrates trap > jump > taken branch. A redirect that arrives while fetch
// is memory-stalled is held until the stall clears. Every issued redirect
// flushes the front end for FLUSH_CYCLES cycles.
//
// Optional feature macro: MISALIGN_CHECK_EN
//   defined   -> jump/branch targets with target[1:0] != 0 are replaced by
//                TRAP_VECTOR, and misalign pulses alongside the issue/latch.
//   undefined -> targets pass through unmodified, misalign is tied to 0.
module pc_redirect_ctrl #(
    parameter int              XLEN         = 32,
    parameter int              FLUSH_CYCLES = 2,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_target,
    input  logic             jump_valid,
    input  logic [XLEN-1:0]  jump_target,
    input  logic             trap_req,
    input  logic             hazard_stall,
    input  logic             mem_stall,
    output logic             stall_pc,
    output logic             pc_update_control,
    output logic [XLEN-1:0]  pc_update_val,
    output logic             flush_fe,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic             misalign
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Arbitrated redirect request for the current cycle.
    typedef struct packed {
        logic            vld;
        logic [XLEN-1:0] tgt;
        logic            mis;
    } redir_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        fcnt_q, fcnt_d;
    logic [XLEN-1:0]   pend_q, pend_d;
    logic              stall_d, upd_d, flush_d, mis_d;
    logic [XLEN-1:0]   val_d;
    logic [CNT_W-1:0]  rcnt_d, rcnt_inc;
    redir_t            rq;

    // Saturating increment of the redirect counter.
    assign rcnt_inc = (redirect_cnt == '1) ? redirect_cnt : redirect_cnt + CNT_W'(1);

    // Request arbitration: trap beats jump beats taken branch.
    always_comb begin
        rq.vld = trap_req | jump_valid | (br_valid & br_taken);
        rq.tgt = br_target;
        rq.mis = 1'b0;
        if (trap_req)
            rq.tgt = TRAP_VECTOR;
        else if (jump_valid)
            rq.tgt = jump_target;
`ifdef MISALIGN_CHECK_EN
        if (rq.vld && !trap_req && (rq.tgt[1:0] != 2'b00)) begin
            rq.tgt = TRAP_VECTOR;
            rq.mis = 1'b1;
        end
`endif
    end

    // Next-state and next-output logic for the redirect FSM.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pend_d  = pend_q;
        stall_d = 1'b0;
        upd_d   = 1'b0;
        val_d   = pc_update_val;
        flush_d = 1'b0;
        rcnt_d  = redirect_cnt;
        mis_d   = 1'b0;

        unique case (state_q)
            PEND: begin
                // Younger jumps/branches are ignored; only a trap can retarget.
                if (trap_req)
                    pend_d = TRAP_VECTOR;
                if (!mem_stall) begin
                    upd_d   = 1'b1;
                    val_d   = trap_req ? TRAP_VECTOR : pend_q;
                    flush_d = 1'b1;
                    fcnt_d  = FLUSH_INIT;
                    rcnt_d  = rcnt_inc;
                    state_d = FLUSH;
                end else begin
                    stall_d = 1'b1;
                end
            end
            default: begin
                // IDLE and FLUSH share the request path; they differ only
                // in how they behave with no request.
                if (rq.vld) begin
                    mis_d = rq.mis;
                    if (mem_stall) begin
                        pend_d  = rq.tgt;
                        stall_d = 1'b1;
                        fcnt_d  = '0;
                        state_d = PEND;
                    end else begin
                        upd_d   = 1'b1;
                        val_d   = rq.tgt;
                        flush_d = 1'b1;
                        fcnt_d  = FLUSH_INIT;
                        rcnt_d  = rcnt_inc;
                        state_d = FLUSH;
                    end
                end else if (state_q == FLUSH) begin
                    // hazard_stall belongs to an instruction being flushed.
                    stall_d = mem_stall;
                    if (fcnt_q <= 4'd1) begin
                        fcnt_d  = '0;
                        state_d = IDLE;
                    end else begin
                        fcnt_d  = fcnt_q - 4'd1;
                        flush_d = 1'b1;
                    end
                end else begin
                    stall_d = hazard_stall | mem_stall;
                end
            end
        endcase
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q           <= IDLE;
            fcnt_q            <= '0;
            pend_q            <= '0;
            stall_pc          <= 1'b0;
            pc_update_control <= 1'b0;
            pc_update_val     <= '0;
            flush_fe          <= 1'b0;
            redirect_cnt      <= '0;
            misalign          <= 1'b0;
        end else begin
            state_q           <= state_d;
            fcnt_q            <= fcnt_d;
            pend_q            <= pend_d;
            stall_pc          <= stall_d;
            pc_update_control <= upd_d;
            pc_update_val     <= val_d;
            flush_fe          <= flush_d;
            redirect_cnt      <= rcnt_d;
            misalign          <= mis_d;
        end
    end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Drives the PC generator's control interface (stall_pc, pc_update_control, pc_update_val) from execute-stage branch/jump resolution, trap requests, and hazard/memory stall sources. Arbitrates redirect priority, holds a redirect while the fetch side is memory-stalled, and flushes the front end for a fixed number of cycles after each redirect. Sits between the execute/hazard units and the PC generator.

Parameters:
XLEN, 32, address/PC width
FLUSH_CYCLES, 2, cycles flush_fe stays high after a redirect is issued (legal range 1..15)
TRAP_VECTOR, 32'h0000_0100, redirect target for trap requests
CNT_W, 16, width of redirect event counter

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  synchronous, active-high reset
br_valid  input  1  resolved conditional branch in EX this cycle
br_taken  input  1  branch taken (front end predicts not-taken)
br_target  input  XLEN  taken-branch target
jump_valid  input  1  JAL/JALR resolved in EX this cycle
jump_target  input  XLEN  jump target
trap_req  input  1  trap/exception request
hazard_stall  input  1  load-use stall (younger instr; cancelled by redirect)
mem_stall  input  1  fetch memory busy (must be honoured)
stall_pc  output  1  to PC generator: hold PC
pc_update_control  output  1  to PC generator: load pc_update_val (1-cycle pulse)
pc_update_val  output  XLEN  redirect target
flush_fe  output  1  kill IF/ID contents
redirect_cnt  output  CNT_W  saturating count of issued redirects
misalign  output  1  1-cycle pulse, misaligned target detected (see feature)

Behaviour:
- All outputs registered. Reset (i_rst=1 at edge): every output 0, state IDLE, flush counter 0, pending target 0, redirect_cnt 0. Reset in PEND/FLUSH discards pending redirect and flush.
- Request this cycle: req = trap_req | jump_valid | (br_valid & br_taken). Target priority: trap (TRAP_VECTOR) > jump (jump_target) > branch (br_target). br_valid & ~br_taken is not a request.
- Latency: request sampled at edge N; pc_update_control/pc_update_val valid in cycle N+1; PC generator loads at edge N+1.
- "Issue" = pc_update_control<=1, pc_update_val<=target, stall_pc<=0, flush_fe<=1, flush counter<=FLUSH_CYCLES, redirect_cnt<=redirect_cnt+1 (saturate at all-ones), state->FLUSH.
- pc_update_control is high exactly one cycle per issue; pc_update_val holds last issued value otherwise.
- IDLE: req & ~mem_stall -> issue. req & mem_stall -> latch target into pending reg, stall_pc<=1, ->PEND. No req -> stall_pc<=hazard_stall|mem_stall, flush_fe<=0.
- PEND: stall_pc<=1. trap_req overwrites pending target with TRAP_VECTOR; jump/branch requests ignored (younger, will be flushed). mem_stall low -> issue pending target (trap in the same cycle wins).
- FLUSH: flush_fe=1; counter decrements each cycle; hazard_stall ignored; stall_pc<=mem_stall. New req handled as in IDLE (issue reloads counter; with mem_stall -> PEND, flush_fe<=0). Counter ==1 with no req -> flush_fe<=0, ->IDLE.
- hazard_stall and req same cycle: redirect wins, no stall asserted.
- pc_update_control and stall_pc never both 1.

Optional Feature:
MISALIGN_CHECK_EN: defined -> jump/branch target with target[1:0]!=0 is replaced by TRAP_VECTOR and misalign pulses 1 cycle alongside the issue (or the PEND latch); counts as one redirect. Undefined -> targets passed unmodified, misalign tied 0.

Test Plan:
- Reset: hold i_rst 2 cycles mid-traffic -> all outputs 0, redirect_cnt=0, next cycle no stall/flush.
- br_valid=1,br_taken=1,br_target=0x40 at edge N -> cycle N+1 pc_update_control=1, pc_update_val=0x40, flush_fe=1 for 2 cycles, redirect_cnt=1.
- jump_valid(0x80)+br taken(0x40)+trap_req same cycle -> pc_update_val=0x100; drop trap -> 0x80.
- mem_stall=1, branch to 0x200, mem_stall held 3 cycles -> stall_pc=1, no pulse; 1 cycle after mem_stall drops pc_update_control=1, val=0x200.
- hazard_stall=1 with jump to 0x300 -> stall_pc=0, update pulse 0x300; hazard_stall during FLUSH -> stall_pc stays 0.
- MISALIGN_CHECK_EN: jump_target=0x302 -> pc_update_val=0x100, misalign=1 one cycle; undefined -> val=0x302, misalign=0.
